inst_fetch_unit: RTL and testbench

Instruction-side responder that serves the pipeline's PC fetch requests from a synchronous, 32-bit-wide instruction memory. It supports mixed 16/32-bit (compressed) instruction streams. It keeps a one-word fetch buffer, extracts the instruction at any halfword-aligned PC, and performs a second word read when a 32-bit instruction straddles a word boundary. It sits between the PC register (IF stage) and the instruction BRAM, and drives the IF/ID instruction and stall.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/inst_align.sv | 31 +++
 rtl/inst_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    WT0,
    RD1,
    WT1,
    RESP
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // A halfword starts a compressed instruction unless its two low bits are 11.
  function automatic logic is_rvc(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/inst_align.sv
// Extracts the instruction at a halfword-aligned PC from one or two memory words.
// word_hi only needs the low half of the following word, which is all a
// straddling instruction ever consumes.
module inst_align
  import fetch_pkg::*;
(
  input  logic [31:0] word_lo,
  input  logic [15:0] word_hi,
  input  logic        pc1,
  input  logic        straddle,
  output logic [31:0] inst,
  output logic        compressed
);

  // Select the halfword(s) that make up the instruction and flag 16-bit ones.
  always_comb begin
    inst       = word_lo;
    compressed = 1'b0;
    if (straddle) begin
      inst       = {word_hi, word_lo[31:16]};
      compressed = 1'b0;
    end else if (pc1) begin
      inst       = {16'h0000, word_lo[31:16]};
      compressed = 1'b1;
    end else if (is_rvc(word_lo[15:0])) begin
      inst       = {16'h0000, word_lo[15:0]};
      compressed = 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch responder: one-word buffer, halfword alignment and a second
// word read for 32-bit instructions that straddle a word boundary.
module inst_fetch_unit #(
  parameter int          MEM_AW   = 10,
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [31:0]       req_pc,
  input  logic              flush,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_inst,
  output logic [31:0]       rsp_pc,
  output logic              rsp_compressed,
  output logic              busy
);

  import fetch_pkg::*;

  state_t            state;
  logic [31:0]       buf_data;
  logic [MEM_AW-1:0] buf_tag;
  logic              buf_valid;
  logic [15:0]       hold_hi;
  logic [31:0]       pc_q;

  logic [MEM_AW-1:0] w_req;
  logic [MEM_AW-1:0] w_req_nxt;
  logic [MEM_AW-1:0] w_cur;
  logic [MEM_AW-1:0] w_cur_nxt;
  logic              hit;

  logic [31:0]       al_lo;
  logic [15:0]       al_hi;
  logic              al_pc1;
  logic              al_straddle;
  logic [31:0]       al_inst;
  logic              al_comp;

  assign w_req     = req_pc[MEM_AW+1:2];
  assign w_req_nxt = w_req + MEM_AW'(1);
  assign w_cur     = pc_q[MEM_AW+1:2];
  assign w_cur_nxt = w_cur + MEM_AW'(1);
  assign hit       = buf_valid && (buf_tag == w_req);
  assign busy      = req_valid & ~rsp_valid;

  // Feed the aligner from the buffer (hit path), fresh memory data (after a
  // first read) or the saved upper half plus fresh data (after a second read).
  always_comb begin
    al_lo  = buf_data;
    al_hi  = mem_rdata[15:0];
    al_pc1 = pc_q[1];
    case (state)
      IDLE: begin
        al_lo  = buf_data;
        al_pc1 = req_pc[1];
      end
      WT0:     al_lo = mem_rdata;
      WT1:     al_lo = {hold_hi, 16'h0000};
      default: al_lo = buf_data;
    endcase
    al_straddle = al_pc1 & ~is_rvc(al_lo[31:16]);
  end

  inst_align u_align (
    .word_lo    (al_lo),
    .word_hi    (al_hi),
    .pc1        (al_pc1),
    .straddle   (al_straddle),
    .inst       (al_inst),
    .compressed (al_comp)
  );

  // Fetch FSM with registered memory and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      buf_data       <= '0;
      buf_tag        <= '0;
      buf_valid      <= 1'b0;
      hold_hi        <= '0;
      pc_q           <= '0;
      mem_en         <= 1'b0;
      mem_addr       <= '0;
      rsp_valid      <= 1'b0;
      rsp_inst       <= NOP_INST;
      rsp_pc         <= '0;
      rsp_compressed <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      mem_en    <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              pc_q <= req_pc;
              if (hit && !al_straddle) begin
                state          <= RESP;
                rsp_valid      <= 1'b1;
                rsp_inst       <= al_inst;
                rsp_compressed <= al_comp;
                rsp_pc         <= req_pc;
              end else if (hit) begin
                state    <= RD1;
                mem_en   <= 1'b1;
                mem_addr <= w_req_nxt;
              end else begin
                state    <= RD0;
                mem_en   <= 1'b1;
                mem_addr <= w_req;
              end
            end
          end
          RD0: state <= WT0;
          WT0: begin
            buf_data  <= mem_rdata;
            buf_tag   <= w_cur;
            buf_valid <= 1'b1;
            if (al_straddle) begin
              state    <= RD1;
              mem_en   <= 1'b1;
              mem_addr <= w_cur_nxt;
            end else begin
              state          <= RESP;
              rsp_valid      <= 1'b1;
              rsp_inst       <= al_inst;
              rsp_compressed <= al_comp;
              rsp_pc         <= pc_q;
            end
          end
          RD1: begin
            hold_hi <= buf_data[31:16];
            state   <= WT1;
          end
          WT1: begin
            buf_data       <= mem_rdata;
            buf_tag        <= w_cur_nxt;
            buf_valid      <= 1'b1;
            state          <= RESP;
            rsp_valid      <= 1'b1;
            rsp_inst       <= al_inst;
            rsp_compressed <= al_comp;
            rsp_pc         <= pc_q;
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a synchronous instruction memory model.
module tb_inst_fetch_unit;

  localparam int MEM_AW = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [31:0]       req_pc;
  logic              flush;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_inst;
  logic [31:0]       rsp_pc;
  logic              rsp_compressed;
  logic              busy;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  int                lat;
  int                nrd;
  int                frd;
  logic [MEM_AW-1:0] a0;
  logic [MEM_AW-1:0] a1;
  logic [31:0]       got_inst;
  logic              got_comp;
  logic [31:0]       got_pc;

  inst_fetch_unit #(.MEM_AW(MEM_AW), .NOP_INST(32'h0000_0013)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .flush          (flush),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .rsp_valid      (rsp_valid),
    .rsp_inst       (rsp_inst),
    .rsp_pc         (rsp_pc),
    .rsp_compressed (rsp_compressed),
    .busy           (busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  // Drive one request, record reads and latency until the response pulse.
  task run_req(input logic [31:0] pc);
    lat = -1; nrd = 0; frd = -1; a0 = '0; a1 = '0;
    got_inst = '0; got_comp = 1'b0; got_pc = '0;
    @(negedge clk);
    req_pc = pc;
    req_valid = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_on_req pc=%h got %b want 1", pc, busy);
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_en) begin
        if (nrd == 0) begin
          frd = c;
          a0 = mem_addr;
        end else begin
          a1 = mem_addr;
        end
        nrd++;
      end
      if (rsp_valid) begin
        lat = c;
        got_inst = rsp_inst;
        got_comp = rsp_compressed;
        got_pc = rsp_pc;
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("[TB] FAIL busy_on_rsp pc=%h got %b want 0", pc, busy);
        end
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task test_reset();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++;
    if (rsp_inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL reset_rsp_inst got %h want 00000013", rsp_inst); end
    checks++;
    if (rsp_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_pc got %h want 0", rsp_pc); end
    checks++;
    if (rsp_compressed !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_comp got %b want 0", rsp_compressed); end
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== '0) begin
      errors++; $display("[TB] FAIL reset_mem got en=%b addr=%0d want en=0 addr=0", mem_en, mem_addr);
    end
  endtask

  task test_miss();
    run_req(32'h0);
    checks++;
    if (lat != 3) begin errors++; $display("[TB] FAIL miss_latency got %0d want 3", lat); end
    checks++;
    if (frd != 1 || a0 !== 10'd0 || nrd != 1) begin
      errors++; $display("[TB] FAIL miss_read got first=%0d addr=%0d n=%0d want 1 0 1", frd, a0, nrd);
    end
    checks++;
    if (got_inst !== 32'h00A0_0093 || got_comp !== 1'b0 || got_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL miss_rsp got %h/%b/%h want 00a00093/0/0", got_inst, got_comp, got_pc);
    end
  endtask

  task test_hit();
    run_req(32'h4);
    checks++;
    if (lat != 3 || got_inst !== 32'h0000_4505 || got_comp !== 1'b1 || got_pc !== 32'h4) begin
      errors++; $display("[TB] FAIL pc4 got lat=%0d %h/%b/%h want 3 00004505/1/4", lat, got_inst, got_comp, got_pc);
    end
    run_req(32'h6);
    checks++;
    if (lat != 1 || nrd != 0) begin errors++; $display("[TB] FAIL hit_timing got lat=%0d reads=%0d want 1 0", lat, nrd); end
    checks++;
    if (got_inst !== 32'h0000_0001 || got_comp !== 1'b1 || got_pc !== 32'h6) begin
      errors++; $display("[TB] FAIL hit_rsp got %h/%b/%h want 00000001/1/6", got_inst, got_comp, got_pc);
    end
  endtask

  task test_straddle_miss();
    run_req(32'hE);
    checks++;
    if (lat != 5) begin errors++; $display("[TB] FAIL straddle_latency got %0d want 5", lat); end
    checks++;
    if (nrd != 2 || a0 !== 10'd3 || a1 !== 10'd4) begin
      errors++; $display("[TB] FAIL straddle_reads got n=%0d %0d,%0d want 2 3,4", nrd, a0, a1);
    end
    checks++;
    if (got_inst !== 32'h00A0_0093 || got_comp !== 1'b0 || got_pc !== 32'hE) begin
      errors++; $display("[TB] FAIL straddle_rsp got %h/%b/%h want 00a00093/0/e", got_inst, got_comp, got_pc);
    end
  endtask

  task test_back_to_back();
    run_req(32'hC);
    checks++;
    if (lat != 3 || got_inst !== 32'h0000_0001 || got_comp !== 1'b1) begin
      errors++; $display("[TB] FAIL pcC got lat=%0d %h/%b want 3 00000001/1", lat, got_inst, got_comp);
    end
    run_req(32'hE);
    checks++;
    if (lat != 3 || nrd != 1 || a0 !== 10'd4) begin
      errors++; $display("[TB] FAIL straddle_hit_timing got lat=%0d n=%0d addr=%0d want 3 1 4", lat, nrd, a0);
    end
    checks++;
    if (got_inst !== 32'h00A0_0093 || got_pc !== 32'hE) begin
      errors++; $display("[TB] FAIL straddle_hit_rsp got %h/%h want 00a00093/e", got_inst, got_pc);
    end
  endtask

  task test_flush();
    logic seen;
    @(negedge clk);
    req_pc = 32'h4;
    req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 10'd1) begin
      errors++; $display("[TB] FAIL flush_rd0 got en=%b addr=%0d want 1 1", mem_en, mem_addr);
    end
    @(posedge clk); @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_rsp got %b want 0", seen); end
    run_req(32'h10);
    checks++;
    if (lat != 1 || got_inst !== 32'h0000_00A0 || got_comp !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_buf_kept got lat=%0d %h/%b want 1 000000a0/1", lat, got_inst, got_comp);
    end
    run_req(32'h0);
    checks++;
    if (lat != 3 || got_inst !== 32'h00A0_0093) begin
      errors++; $display("[TB] FAIL after_flush got lat=%0d %h want 3 00a00093", lat, got_inst);
    end
  endtask

  task test_flush_idle();
    @(negedge clk);
    req_pc = 32'h0;
    req_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_wins got rsp=%b en=%b want 0 0", rsp_valid, mem_en);
    end
    flush = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_inst !== 32'h00A0_0093) begin
      errors++; $display("[TB] FAIL flush_resample got rsp=%b %h want 1 00a00093", rsp_valid, rsp_inst);
    end
    req_valid = 1'b0;
  endtask

  task test_reset_mid();
    @(negedge clk);
    req_pc = 32'hE;
    req_valid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_inst !== 32'h0000_0013 || rsp_pc !== 32'h0 || rsp_compressed !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_rsp got %b/%h/%h/%b want 0/00000013/0/0", rsp_valid, rsp_inst, rsp_pc, rsp_compressed);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== '0) begin
      errors++; $display("[TB] FAIL midrst_mem got en=%b addr=%0d want 0 0", mem_en, mem_addr);
    end
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    run_req(32'hC);
    checks++;
    if (lat != 3 || nrd != 1 || a0 !== 10'd3 || got_inst !== 32'h0000_0001) begin
      errors++; $display("[TB] FAIL midrst_miss got lat=%0d n=%0d addr=%0d %h want 3 1 3 00000001", lat, nrd, a0, got_inst);
    end
  endtask

  task test_wrap();
    run_req(32'hFFE);
    checks++;
    if (lat != 5 || nrd != 2 || a0 !== 10'd1023 || a1 !== 10'd0) begin
      errors++; $display("[TB] FAIL wrap_reads got lat=%0d n=%0d %0d,%0d want 5 2 1023,0", lat, nrd, a0, a1);
    end
    checks++;
    if (got_inst !== 32'h0093_40B3 || got_comp !== 1'b0 || got_pc !== 32'hFFE) begin
      errors++; $display("[TB] FAIL wrap_rsp got %h/%b/%h want 009340b3/0/ffe", got_inst, got_comp, got_pc);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]    = 32'h00A0_0093;
    mem[1]    = 32'h0001_4505;
    mem[3]    = 32'h0093_0001;
    mem[4]    = 32'h1234_00A0;
    mem[1023] = 32'h40B3_0513;
    mem_rdata = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0;
    flush = 1'b0;
    req_pc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_miss();
    test_hit();
    test_straddle_miss();
    test_back_to_back();
    test_flush();
    test_flush_idle();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
